keypad_entry_display: RTL and testbench
=======================================

KEYPAD_ENTRY_DISPLAY -- requirements
Module: keypad_entry_display

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive clk cycles a new key code must be stable before acceptance (10 ms at 100 MHz).
REQ-002 SHALL have parameter REFRESH_CYCLES, default 100000, clk cycles each display digit is driven.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port DecodeOut  input  4  held key code from the numpad decoder, clk domain, no handshake.
REQ-006 SHALL have port key_pulse  output  1  one-cycle strobe on each accepted key.
REQ-007 SHALL have port key_code  output  4  code of the last accepted key.
REQ-008 SHALL have port entry  output  16  four-digit hex entry register, digit 0 = bits [3:0] (newest).
REQ-009 SHALL have port seg  output  7  seven-segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an  output  4  digit anodes, active-low, an[0] = digit 0.

Function
REQ-011 Key FSM SHALL have states SYNC, IDLE, DEBOUNCE.
REQ-012 SYNC: on the first cycle after reset, DecodeOut SHALL be captured into last_key with no key_pulse, then IDLE.
REQ-013 IDLE: when DecodeOut != last_key, cand SHALL load DecodeOut, debounce counter SHALL clear to 0, state SHALL go to DEBOUNCE.
REQ-014 DEBOUNCE: counter SHALL increment each cycle while DecodeOut == cand.
REQ-015 DEBOUNCE: if DecodeOut changes to a value other than cand and last_key, cand SHALL reload, and counter SHALL clear while remaining in DEBOUNCE.
REQ-016 DEBOUNCE: if DecodeOut returns to last_key, state SHALL go to IDLE with no event.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 with DecodeOut == cand, the next edge SHALL set last_key = cand, key_code = cand, key_pulse = 1 for exactly one cycle, state to IDLE.
REQ-018 A repeated press of the same key produces no change on DecodeOut and SHALL produce no event.
REQ-019 On an accepted key k != 4'hF, entry SHALL become {entry[11:0], k} in the same cycle key_pulse is high; the oldest digit is discarded.
REQ-020 On an accepted key 4'hF, entry SHALL clear to 16'h0000; key_pulse and key_code behave as for any key.
REQ-021 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES) and SHALL never wrap.
REQ-022 Refresh counter SHALL count 0..REFRESH_CYCLES-1 and then wrap to 0, advancing a 2-bit digit index 0->1->2->3->0 on each wrap.
REQ-023 Exactly one an bit SHALL be low at a time, selected by the digit index.
REQ-024 seg SHALL be the registered hex decode of entry nibble[index] (0-9, A-F standard glyphs; 0 = 7'b1000000, 8 = 7'b0000000), updated in the same cycle as an.
REQ-025 entry updates SHALL appear on seg no later than the next digit slot, with no glitch across an boundaries.

Reset
REQ-026 Asserting rst at any time, including mid-DEBOUNCE, SHALL immediately force state SYNC.
REQ-027 Asserting rst SHALL immediately force last_key = cand = key_code = 4'h0, entry = 16'h0000, key_pulse = 0, and both counters = 0.
REQ-028 Asserting rst SHALL immediately force digit index = 0, an = 4'b1110, seg = 7'b1000000.
REQ-029 No event SHALL be generated by the value of DecodeOut present at reset release.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the CLEAR_KEY constant (4'hF) and the hex-to-seven-segment table as a function.
REQ-031 Display multiplexing SHALL be a sub-module seg7_mux (clk, rst, 16-bit value in, seg/an out); key FSM and entry register stay in the top module.

Verification
REQ-032 Reset, DecodeOut=4'h0, then 5 after 2 cycles held DEBOUNCE_CYCLES+2 -> one key_pulse, key_code=5, entry=16'h0005.
REQ-033 Keys 1,2,3,4,7 each held stable -> five pulses, entry=16'h2347.
REQ-034 DecodeOut 4 held DEBOUNCE_CYCLES/2 then back to previous value -> no pulse, entry unchanged.
REQ-035 Entry 16'h1234 then key F -> pulse with key_code=F, entry=16'h0000.
REQ-036 rst asserted mid-DEBOUNCE -> outputs at reset values that cycle; no pulse after release for the held value.
REQ-037 With REFRESH_CYCLES=4 and entry=16'hA1B0 -> an sequences 1110,1101,1011,0111 every 4 cycles; seg = glyphs 0, B, 1, A respectively.

Source files
------------

// File: rtl/keypad_entry_display_pkg.sv
// Shared definitions for the keypad entry block: key FSM states, the clear key
// and the hex to seven-segment glyph table.
package keypad_entry_display_pkg;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    IDLE     = 2'd1,
    DEBOUNCE = 2'd2
  } key_state_e;

  localparam logic [3:0] CLEAR_KEY = 4'hF;

  // Active-low cathodes ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/keypad_entry_display_seg7_mux.sv
// Time-multiplexed four digit seven-segment driver; seg and an are registered
// together so a digit switch never shows the wrong glyph.
module seg7_mux
  import keypad_entry_display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0]   rcnt;
  logic [1:0]      idx;
  logic [1:0]      nxt_idx;
  logic            wrap;
  logic [3:0][3:0] nib;

  assign nib     = value;
  assign wrap    = (rcnt == RCNT_LAST);
  assign nxt_idx = wrap ? idx + 2'd1 : idx;

  // seg is refreshed every cycle so entry changes show up within the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= 2'd0;
      an   <= 4'b1110;
      seg  <= 7'b1000000;
    end else begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      idx  <= nxt_idx;
      an   <= ~(4'b0001 << nxt_idx);
      seg  <= hex2seg(nib[nxt_idx]);
    end
  end

endmodule

// File: rtl/keypad_entry_display.sv
// Debounced keypad capture into a four digit hex entry register, shown on a
// multiplexed seven-segment display.
module keypad_entry_display
  import keypad_entry_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  DecodeOut,
  output logic        key_pulse,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  key_state_e    state;
  logic [3:0]    last_key;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      last_key  <= 4'h0;
      cand      <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_pulse <= 1'b0;
      entry     <= 16'h0000;
    end else begin
      key_pulse <= 1'b0;
      case (state)
        // Adopt whatever is held at release so it never counts as a press.
        SYNC: begin
          last_key <= DecodeOut;
          state    <= IDLE;
        end
        IDLE: begin
          if (DecodeOut != last_key) begin
            cand  <= DecodeOut;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (DecodeOut == cand) begin
            if (cnt == CNT_LAST) begin
              last_key  <= cand;
              key_code  <= cand;
              key_pulse <= 1'b1;
              entry     <= (cand == CLEAR_KEY) ? 16'h0000 : {entry[11:0], cand};
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (DecodeOut == last_key) begin
            state <= IDLE;
          end else begin
            cand <= DecodeOut;
            cnt  <= '0;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  seg7_mux #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_mux (
    .clk  (clk),
    .rst  (rst),
    .value(entry),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display with a run-length key model and a
// time-based display model checked every cycle.
module tb_keypad_entry_display;

  localparam int D = 8;
  localparam int R = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk;
  logic        rst;
  logic [3:0]  DecodeOut;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  keypad_entry_display #(
    .DEBOUNCE_CYCLES(D),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DecodeOut(DecodeOut),
    .key_pulse(key_pulse),
    .key_code (key_code),
    .entry    (entry),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is accepted once it has been seen on D+1 consecutive edges
  // and differs from the last accepted key; the first edge after reset adopts.
  bit          m_sync;
  int          run;
  logic [3:0]  prev_din;
  logic [3:0]  m_last;
  logic        m_pulse;
  logic [3:0]  m_code;
  logic [15:0] m_entry;
  logic [15:0] m_src;
  int          m_k;
  int          m_idx;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync = 1'b1; run = 0; prev_din = 4'h0; m_last = 4'h0;
      m_pulse = 1'b0; m_code = 4'h0; m_entry = 16'h0; m_k = 0;
      m_an = 4'b1110; m_seg = GLYPH[0];
    end else begin
      m_src   = m_entry;
      m_pulse = 1'b0;
      if (m_sync) begin
        m_sync = 1'b0; m_last = DecodeOut; prev_din = DecodeOut; run = 0;
      end else begin
        if (run > 0 && DecodeOut == prev_din) run = (run <= D) ? run + 1 : run;
        else run = 1;
        prev_din = DecodeOut;
        if (DecodeOut != m_last && run == D + 1) begin
          m_last  = DecodeOut;
          m_code  = DecodeOut;
          m_pulse = 1'b1;
          m_entry = (DecodeOut == 4'hF) ? 16'h0 : {m_entry[11:0], DecodeOut};
        end
      end
      m_k++;
      m_idx = (m_k / R) % 4;
      m_an  = ~(4'b0001 << m_idx);
      m_seg = GLYPH[(m_src >> (4 * m_idx)) & 16'hF];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("entry", 32'(entry), 32'(m_entry));
      chk("an", 32'(an), 32'(m_an));
      chk("seg", 32'(seg), 32'(m_seg));
      if (key_pulse) pulses++;
    end
  end

  task automatic press(input logic [3:0] k, input int n);
    DecodeOut = k;
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] seen;
  int         p0;

  initial begin
    rst = 1'b1;
    DecodeOut = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_entry", 32'(entry), 32'h0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_pulse", 32'(key_pulse), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    press(4'h5, D + 2);
    chk("k5_pulses", 32'(pulses), 32'd1);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_entry", 32'(entry), 32'h0005);
    chk("k5_model", 32'(m_entry), 32'h0005);

    p0 = pulses;
    press(4'h1, D + 2); press(4'h2, D + 2); press(4'h3, D + 2);
    press(4'h4, D + 2); press(4'h7, D + 2);
    chk("seq_pulses", 32'(pulses - p0), 32'd5);
    chk("seq_entry", 32'(entry), 32'h2347);

    p0 = pulses;
    press(4'h4, D / 2);
    press(4'h7, D + 2);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_entry", 32'(entry), 32'h2347);

    press(4'h1, D + 2); press(4'h2, D + 2); press(4'h3, D + 2); press(4'h4, D + 2);
    chk("pre_clr_entry", 32'(entry), 32'h1234);
    p0 = pulses;
    press(4'hF, D + 2);
    chk("clr_pulses", 32'(pulses - p0), 32'd1);
    chk("clr_code", 32'(key_code), 32'hF);
    chk("clr_entry", 32'(entry), 32'h0000);

    press(4'hA, D + 2); press(4'h1, D + 2); press(4'hB, D + 2); press(4'h0, D + 2);
    chk("disp_entry", 32'(entry), 32'hA1B0);
    seen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin chk("disp_d0", 32'(seg), 32'(GLYPH[0]));  seen[0] = 1'b1; end
        4'b1101: begin chk("disp_d1", 32'(seg), 32'(GLYPH[11])); seen[1] = 1'b1; end
        4'b1011: begin chk("disp_d2", 32'(seg), 32'(GLYPH[1]));  seen[2] = 1'b1; end
        4'b0111: begin chk("disp_d3", 32'(seg), 32'(GLYPH[10])); seen[3] = 1'b1; end
        default: chk("disp_onehot", 32'(an), 32'b1110);
      endcase
    end
    chk("disp_all_digits", 32'(seen), 32'hF);

    DecodeOut = 4'h6;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pulse", 32'(key_pulse), 32'h0);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    chk("mid_rst_entry", 32'(entry), 32'h0);
    chk("mid_rst_an", 32'(an), 32'b1110);
    chk("mid_rst_seg", 32'(seg), 32'b1000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (D + 4) @(negedge clk);
    chk("post_rst_pulses", 32'(pulses - p0), 32'd0);
    chk("post_rst_entry", 32'(entry), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
